alarm_sequencer: RTL and testbench

- Avalon-MM slave that sequences the alarm function of the alarm-clock SoC.
- Synchronises and debounces the raw alarm-enable switch (SWC_ALARM).
- Compares the running time-of-day against a programmed alarm time and drives the buzzer through a ring/snooze state machine.
- Raises an interrupt to the Nios II CPU. Sits beside the timekeeping counter and the switch/LED PIOs on the system interconnect.

---
 rtl/alarm_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_alarm_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
// -----------------------------------------------------------------------------
// alarm_sequencer
//   Avalon-MM slave that runs the alarm function of the alarm-clock SoC.
//   Debounces the alarm-enable switch, matches the time of day against the
//   programmed alarm time once per second, drives the buzzer through a
//   DISABLED/ARMED/RINGING/SNOOZE state machine and raises a level interrupt.
//
// Ports
//   clk        system clock (single domain)
//   reset      synchronous, active-high reset
//   address    register select: 0 CTRL/STATUS, 1 ALARM_TIME, 2 SNOOZE_LEN,
//              3 TIME_NOW
//   read       read strobe (readdata is refreshed every cycle regardless)
//   write      write strobe
//   writedata  write data
//   readdata   registered read data, one cycle after address
//   swc_alarm  raw alarm-enable switch, asynchronous to clk
//   time_sec   current seconds of day, 0..86399
//   tick_1hz   one-cycle pulse per second
//   buzzer     registered alarm sound enable
//   irq        level interrupt, follows irq_pending
// -----------------------------------------------------------------------------
module alarm_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
  parameter logic [7:0]  SNOOZE_DEFAULT  = 8'd60,
  parameter logic [7:0]  RING_TIMEOUT    = 8'd120
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  address,
  input  logic        read,
  input  logic        write,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  input  logic        swc_alarm,
  input  logic [16:0] time_sec,
  input  logic        tick_1hz,
  output logic        buzzer,
  output logic        irq
);

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    ARMED    = 2'd1,
    RINGING  = 2'd2,
    SNOOZE   = 2'd3
  } state_t;

  localparam logic [31:0] LAST_SEC = 32'd86399;

  // A programmed snooze of zero seconds would never expire; treat it as one.
  function automatic logic [7:0] clamp_snooze(input logic [7:0] val);
    return (val == 8'd0) ? 8'd1 : val;
  endfunction

  state_t       state, state_next;
  logic         sync0, sync1, sw_db;
  logic [15:0]  db_cnt;
  logic [16:0]  alarm_time;
  logic [7:0]   snooze_len;
  logic [7:0]   ring_cnt, ring_cnt_next;
  logic [7:0]   snooze_cnt, snooze_cnt_next;
  logic         irq_pending, irq_set;
  logic         ctrl_wr, ack, snz, irq_clr;

  // readdata is refreshed from address every cycle, so the read strobe
  // carries no information for this slave.
  logic unused_read;
  assign unused_read = read;

  assign ctrl_wr = write && (address == 2'd0);
  assign ack     = ctrl_wr && writedata[0];
  assign snz     = ctrl_wr && writedata[1];
  assign irq_clr = ctrl_wr && writedata[2];
  assign irq     = irq_pending;

  // Switch synchroniser and debounce: sw_db follows sync1 only after the two
  // have disagreed for DEBOUNCE_CYCLES consecutive cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync0  <= 1'b0;
      sync1  <= 1'b0;
      sw_db  <= 1'b0;
      db_cnt <= 16'd0;
    end else begin
      sync0 <= swc_alarm;
      sync1 <= sync0;
      if (sync1 != sw_db) begin
        if (db_cnt == DEBOUNCE_CYCLES - 16'd1) begin
          sw_db  <= sync1;
          db_cnt <= 16'd0;
        end else begin
          db_cnt <= db_cnt + 16'd1;
        end
      end else begin
        db_cnt <= 16'd0;
      end
    end
  end

  // Next-state logic. A released switch overrides every other event,
  // including a pending irq set.
  always_comb begin
    state_next      = state;
    irq_set         = 1'b0;
    ring_cnt_next   = ring_cnt;
    snooze_cnt_next = snooze_cnt;
    case (state)
      DISABLED: begin
        if (sw_db) state_next = ARMED;
      end
      ARMED: begin
        if (tick_1hz && (time_sec == alarm_time)) begin
          state_next    = RINGING;
          irq_set       = 1'b1;
          ring_cnt_next = 8'd0;
        end
      end
      RINGING: begin
        if (ack) begin
          state_next = ARMED;
        end else if (snz) begin
          state_next      = SNOOZE;
          snooze_cnt_next = snooze_len;
        end else if (tick_1hz) begin
          if (ring_cnt == RING_TIMEOUT - 8'd1) state_next = ARMED;
          else ring_cnt_next = ring_cnt + 8'd1;
        end
      end
      SNOOZE: begin
        if (ack) begin
          state_next = ARMED;
        end else if (tick_1hz) begin
          if (snooze_cnt == 8'd1) begin
            state_next      = RINGING;
            irq_set         = 1'b1;
            ring_cnt_next   = 8'd0;
            snooze_cnt_next = 8'd0;
          end else begin
            snooze_cnt_next = snooze_cnt - 8'd1;
          end
        end
      end
      default: state_next = DISABLED;
    endcase
    if (!sw_db) begin
      state_next = DISABLED;
      irq_set    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= DISABLED;
      buzzer      <= 1'b0;
      irq_pending <= 1'b0;
      ring_cnt    <= 8'd0;
      snooze_cnt  <= 8'd0;
      alarm_time  <= 17'd0;
      snooze_len  <= SNOOZE_DEFAULT;
      readdata    <= 32'd0;
    end else begin
      state       <= state_next;
      buzzer      <= (state_next == RINGING);
      // A set in the same cycle as IRQ_CLR wins.
      irq_pending <= irq_set | (irq_pending & ~irq_clr);
      ring_cnt    <= ring_cnt_next;
      snooze_cnt  <= snooze_cnt_next;
      if (write && (address == 2'd1) && (writedata <= LAST_SEC))
        alarm_time <= writedata[16:0];
      if (write && (address == 2'd2))
        snooze_len <= clamp_snooze(writedata[7:0]);
      case (address)
        2'd0:    readdata <= {26'd0, state, 1'b0, irq_pending, buzzer, sw_db};
        2'd1:    readdata <= {15'd0, alarm_time};
        2'd2:    readdata <= {24'd0, snooze_len};
        default: readdata <= {15'd0, time_sec};
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alarm_sequencer
//   Directed bench for alarm_sequencer with a short debounce window (8 cycles).
//   Inputs change 1 ns after a rising edge; outputs are sampled at that point.
// -----------------------------------------------------------------------------
module tb_alarm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        read, write;
  logic [31:0] writedata, readdata;
  logic        swc_alarm;
  logic [16:0] time_sec;
  logic        tick_1hz;
  logic        buzzer, irq;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alarm_sequencer #(
    .DEBOUNCE_CYCLES(16'd8),
    .SNOOZE_DEFAULT (8'd60),
    .RING_TIMEOUT   (8'd120)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .swc_alarm(swc_alarm),
    .time_sec (time_sec),
    .tick_1hz (tick_1hz),
    .buzzer   (buzzer),
    .irq      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    step();
    d    = readdata;
    read = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    step();
    write     = 1'b0;
    writedata = 32'd0;
  endtask

  task automatic tick();
    tick_1hz = 1'b1;
    step();
    tick_1hz = 1'b0;
  endtask

  logic [31:0] d;
  logic        seen;
  int          fell;

  initial begin
    reset = 1'b1; address = 2'd0; read = 1'b0; write = 1'b0; writedata = 32'd0;
    swc_alarm = 1'b0; time_sec = 17'd12345; tick_1hz = 1'b0;
    step();
    step();
    chk("rst_rdata", readdata, 32'd0);
    chk("rst_buzzer", buzzer, 32'd0);
    chk("rst_irq", irq, 32'd0);
    reset = 1'b0;

    rd(2'd0, d); chk("rd_ctrl", d, 32'd0);
    rd(2'd1, d); chk("rd_alarm", d, 32'd0);
    rd(2'd2, d); chk("rd_snooze", d, 32'd60);
    rd(2'd3, d); chk("rd_now", d, 32'd12345);

    // Bouncing switch never settles long enough.
    address = 2'd0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      swc_alarm = ((i / 3) % 2) == 0;
      step();
      seen |= readdata[0];
    end
    chk("bounce_db", seen, 32'd0);

    // Held high: sw_db rises on the 10th edge, visible in readdata one later.
    swc_alarm = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      step();
      if (k == 10) chk("db_k10", readdata[0], 32'd0);
      if (k == 11) chk("db_k11", readdata[0], 32'd1);
      if (k == 12) chk("armed", readdata, 32'h11);
    end

    // Alarm match, IRQ clear, ACK.
    wr(2'd1, 32'd25200);
    time_sec = 17'd25200;
    tick();
    chk("ring_buzzer", buzzer, 32'd1);
    chk("ring_irq", irq, 32'd1);
    rd(2'd0, d); chk("ring_status", d, 32'h27);
    wr(2'd0, 32'h4);
    chk("clr_irq", irq, 32'd0);
    chk("clr_buzzer", buzzer, 32'd1);
    wr(2'd0, 32'h1);
    chk("ack_buzzer", buzzer, 32'd0);
    rd(2'd0, d); chk("ack_status", d, 32'h11);

    // Snooze of 3 seconds.
    wr(2'd2, 32'd3);
    tick();
    chk("ring2_buzzer", buzzer, 32'd1);
    time_sec = 17'd25201;
    wr(2'd0, 32'h2);
    chk("snz_buzzer", buzzer, 32'd0);
    rd(2'd0, d); chk("snz_status", d, 32'h35);
    wr(2'd0, 32'h4);
    chk("snz_clr_irq", irq, 32'd0);
    tick();
    tick();
    chk("snz_2ticks", buzzer, 32'd0);
    tick();
    chk("snz_expire_buzzer", buzzer, 32'd1);
    chk("snz_expire_irq", irq, 32'd1);
    rd(2'd0, d); chk("snz_expire_status", d, 32'h27);

    // Ring timeout after 120 ticks.
    for (int n = 0; n < 119; n++) tick();
    chk("tmo_119", buzzer, 32'd1);
    tick();
    chk("tmo_120", buzzer, 32'd0);
    rd(2'd0, d); chk("tmo_status", d, 32'h15);

    // ACK and SNOOZE together: ACK wins.
    time_sec = 17'd25200;
    tick();
    chk("ring3_buzzer", buzzer, 32'd1);
    wr(2'd0, 32'h3);
    chk("both_buzzer", buzzer, 32'd0);
    rd(2'd0, d); chk("both_status", d, 32'h15);

    // Register write boundaries.
    wr(2'd1, 32'd90000);
    rd(2'd1, d); chk("alarm_oor", d, 32'd25200);
    wr(2'd2, 32'd0);
    rd(2'd2, d); chk("snooze_zero", d, 32'd1);
    wr(2'd3, 32'd5);
    rd(2'd3, d); chk("now_ro", d, 32'd25200);

    // Switch released while ringing.
    tick();
    chk("ring4_buzzer", buzzer, 32'd1);
    swc_alarm = 1'b0;
    fell = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (!buzzer && fell == 0) fell = k;
    end
    chk("release_edge", fell, 32'd11);
    rd(2'd0, d); chk("release_status", d, 32'h04);
    chk("release_irq", irq, 32'd1);

    // Reset during SNOOZE.
    swc_alarm = 1'b1;
    repeat (12) step();
    tick();
    chk("ring5_buzzer", buzzer, 32'd1);
    wr(2'd0, 32'h2);
    address = 2'd3;
    step();
    chk("pre_rst_rdata", readdata, 32'd25200);
    reset = 1'b1;
    step();
    chk("mid_rst_buzzer", buzzer, 32'd0);
    chk("mid_rst_irq", irq, 32'd0);
    chk("mid_rst_rdata", readdata, 32'd0);
    reset = 1'b0;
    rd(2'd2, d); chk("mid_rst_snooze", d, 32'd60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
